serial_tx: RTL
==============

# serial_tx

Byte-to-serial transmitter, the sending end of the bit-serial link that the design's deserializer/queue receives. Bytes are pushed into a small internal FIFO, then shifted out one bit at a time on `data_out`. Each byte is framed by `write_out`, which is high for exactly one byte of bit periods and low for at least one inter-frame gap. The block feeds the receiver's `data_in`/`write_in` pair directly.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; power of two, at least 2.
- `BIT_CYCLES`, 2: clock cycles each bit is held on `data_out`; at least 1.
- `GAP_CYCLES`, 1: cycles `write_out` stays low between frames; at least 1.

Ports:
- `clock_1MHz` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `data_in` in 8: byte to enqueue.
- `enqueue_in` in 1: push `data_in` when high at a clock edge.
- `data_out` out 1: serial bit, MSB first.
- `write_out` out 1: frame valid; high while a byte's bits are on `data_out`.
- `status_out` out 1: FIFO full.
- `empty_out` out 1: FIFO empty and no frame in progress.
- `count_out` out $clog2(DEPTH+1): bytes queued, excluding the byte being shifted.
- `overflow_out` out 1: sticky; set when an enqueue is dropped.

## Operation
- FIFO: circular buffer with read/write pointers and an occupancy counter.
  - Push when `enqueue_in` is high and `count_out < DEPTH`.
  - Full is judged on the pre-edge count. A push while full is dropped and sets `overflow_out`, even if a pop happens on the same edge.
  - A push and a pop on the same edge leave `count_out` unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if count > 0, pop the head into the 8-bit shift register, clear the bit and cycle counters, go to SHIFT.
  - SHIFT: `write_out`=1 and `data_out`=shreg[7]. The cycle counter counts 0..BIT_CYCLES-1. At terminal count, shift left by one and increment the bit index. After bit 7's last cycle, go to GAP.
  - GAP: `write_out`=0 and `data_out`=0 for GAP_CYCLES cycles, then go to IDLE.
- `empty_out` = (count == 0) and state == IDLE.
- Reset values: state IDLE, FIFO empty, pointers 0, `data_out`=0, `write_out`=0, `status_out`=0, `empty_out`=1, `count_out`=0, `overflow_out`=0, shift register 0.
- Reset mid-frame:
  - The frame is abandoned and `write_out` is 0 after the reset edge.
  - All queued bytes are discarded.
  - `enqueue_in` is ignored while `rst` is high.

## Timing
- All outputs are registered.
- Latency: a byte enqueued at edge k into an empty FIFO with the FSM in IDLE is loaded at edge k+1. Its MSB and `write_out`=1 are valid after edge k+1.
- Each bit is held exactly BIT_CYCLES cycles. The frame is 8*BIT_CYCLES cycles of `write_out`=1.
- Back-to-back bytes:
  - After the gap, IDLE lasts exactly one cycle before the next frame.
  - Frame period is 8*BIT_CYCLES + GAP_CYCLES + 1 cycles.
  - `write_out` never stays high across two bytes.
- `count_out` decrements on the edge that loads the shift register.

## Configuration
- `SERIAL_TX_PARITY_EN` defined:
  - After bit 0, one extra bit period carries even parity (XOR of the 8 data bits).
  - `write_out` stays high for 9*BIT_CYCLES cycles.
  - The frame period grows by BIT_CYCLES.
- `SERIAL_TX_PARITY_EN` undefined: 8-bit frames only, and no parity logic is instantiated.

## Test plan
- Reset, then enqueue 8'hB6 once with BIT_CYCLES=2.
  - `write_out` is high for 16 cycles starting one cycle after the enqueue edge.
  - `data_out` pairs are 1,0,1,1,0,1,1,0.
  - `empty_out` returns to 1 after the gap.
- Enqueue 8'hA5 and 8'h3C on consecutive cycles.
  - `write_out` shows two 16-cycle frames separated by exactly 2 low cycles (GAP plus IDLE).
  - `count_out` reads 1, then 0 at the second load.
- Enqueue 9 bytes while the FSM holds the first frame, with DEPTH=8.
  - `count_out` peaks at 8 and `status_out`=1.
  - The 10th push is dropped and `overflow_out`=1 until reset.
  - Exactly 9 frames are transmitted.
- With the FIFO full, assert `enqueue_in` on the same edge as a pop.
  - The push is dropped, `count_out` becomes DEPTH-1, and `overflow_out`=1.
- Assert `rst` for 1 cycle at bit 3 of a frame with 3 bytes queued.
  - Next cycle: `write_out`=0, `count_out`=0, `empty_out`=1.
  - No further frames follow.
- With `SERIAL_TX_PARITY_EN` defined, send 8'h07.
  - `write_out` is high for 18 cycles and the final bit period is 1.

Source files
------------

// File: rtl/serial_tx.sv
// Byte-to-serial transmitter: small FIFO feeding an MSB-first shifter framed by write_out.
// Optional even-parity bit after bit 0 when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
  parameter int DEPTH      = 8,
  parameter int BIT_CYCLES = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clock_1MHz,
  input  logic                       rst,
  input  logic [7:0]                 data_in,
  input  logic                       enqueue_in,
  output logic                       data_out,
  output logic                       write_out,
  output logic                       status_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int CYW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int LAST_BIT = 8;
`else
  localparam int LAST_BIT = 7;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      bit_q, bit_d;
  logic [CYW-1:0]  cyc_q, cyc_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            data_q, data_d, write_q, write_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            push, pop, bit_done, last_bit, gap_done, fill_bit;

  assign push     = enqueue_in && (count_q != CW'(DEPTH));
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign bit_done = (cyc_q == CYW'(BIT_CYCLES - 1));
  assign last_bit = (bit_q == 4'(LAST_BIT));
  assign gap_done = (gap_q == GW'(GAP_CYCLES - 1));

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;
  // Parity is latched at load and rides in as the ninth shifted bit.
  assign fill_bit = parity_q;
  always_ff @(posedge clock_1MHz) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = ^mem_q[rd_ptr_q];
  end
`else
  assign fill_bit = 1'b0;
`endif

  always_ff @(posedge clock_1MHz) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SHIFT;
      SHIFT:   if (bit_done && last_bit) state_d = GAP;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (enqueue_in && (count_q == CW'(DEPTH)));
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    gap_d    = gap_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: if (pop) begin
        shreg_d = mem_q[rd_ptr_q];
        bit_d   = '0;
        cyc_d   = '0;
        gap_d   = '0;
      end
      SHIFT: if (bit_done) begin
        cyc_d = '0;
        if (!last_bit) begin
          shreg_d = {shreg_q[6:0], fill_bit};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        cyc_d = cyc_q + CYW'(1);
      end
      GAP:     gap_d = gap_q + GW'(1);
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    write_d = (state_d == SHIFT);
    data_d  = write_d ? shreg_d[7] : 1'b0;
    empty_d = (count_d == '0) && (state_d == IDLE);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      shreg_q  <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      gap_q    <= '0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      write_q  <= write_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clock_1MHz) begin
    if (push && !rst) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_q;
  assign write_out    = write_q;
  assign status_out   = full_q;
  assign empty_out    = empty_q;
  assign count_out    = count_q;
  assign overflow_out = ovf_q;

endmodule
